// File: rtl/fetch_sequencer.sv
// Single-issue fetch front end: owns the PC, fetches one word at a time,
// holds it for the decoder and resolves branch/jump targets at retire.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] imm_ext,
    output logic [31:0] retired_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] p4_q, p4_d;
    logic [31:0] count_q, count_d;
    logic [31:0] next_pc;
    logic        br_taken;
    logic        unused_imm;

    // Word-scaled offset drops the top two immediate bits.
    assign unused_imm = ^imm_ext[31:30];

    always_comb begin
        br_taken = ((branch == 2'b01) && zero) || ((branch == 2'b11) && !zero);
        next_pc  = p4_q;
        if (jump) begin
            next_pc = {p4_q[31:28], instr_q[25:0], 2'b00};
        end else if (br_taken) begin
            next_pc = p4_q + {imm_ext[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        p4_d    = p4_q;
        count_d = count_q;
        unique case (state_q)
            FETCH: begin
                if (req_q && imem_ready) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    p4_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    req_d = 1'b1;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            ipc_q   <= RESET_PC;
            p4_q    <= RESET_PC + 32'd4;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            p4_q    <= p4_d;
            count_q <= count_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign instr_valid   = valid_q;
    assign instr         = instr_q;
    assign instr_pc      = ipc_q;
    assign pc_plus4      = p4_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program walk plus randomized traffic,
// compared each cycle against a transaction-level model.
module tb_fetch_sequencer;

    localparam logic [31:0] RP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_ack;
    logic [1:0]  branch;
    logic        zero;
    logic        jump;
    logic [31:0] imm_ext;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;

    // Model: "holding" an instruction or not, plus the architectural PC.
    logic        m_req;
    logic        m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_cnt;

    fetch_sequencer #(.RESET_PC(RP)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .pc_plus4(pc_plus4),
        .instr_ack(instr_ack),
        .branch(branch),
        .zero(zero),
        .jump(jump),
        .imm_ext(imm_ext),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] target();
        logic [31:0] seq;
        logic [31:0] region;
        logic [31:0] idx;
        seq = m_ipc + 32'd4;
        if (jump) begin
            region = (seq / 32'h1000_0000) * 32'h1000_0000;
            idx    = {6'd0, m_instr[25:0]};
            return region + idx * 32'd4;
        end
        if ((branch == 2'd1 && zero) || (branch == 2'd3 && !zero))
            return seq + imm_ext * 32'd4;
        return seq;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            m_req   = 1'b0;
            m_hold  = 1'b0;
            m_pc    = RP;
            m_instr = 32'h0;
            m_ipc   = RP;
            m_cnt   = 32'h0;
        end else if (m_hold) begin
            if (instr_ack) begin
                m_pc   = target();
                m_hold = 1'b0;
                m_cnt  = m_cnt + 32'd1;
                m_req  = 1'b1;
            end
        end else if (m_req && imem_ready) begin
            m_instr = imem_rdata;
            m_ipc   = m_pc;
            m_hold  = 1'b1;
            m_req   = 1'b0;
        end else begin
            m_req = 1'b1;
        end
        #1;
        check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold});
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("pc_plus4", pc_plus4, m_ipc + 32'd4);
        check("retired_count", retired_count, m_cnt);
    endtask

    task automatic idle_in();
        imem_ready = 1'b0;
        instr_ack  = 1'b0;
        branch     = 2'b00;
        zero       = 1'b0;
        jump       = 1'b0;
        imm_ext    = 32'h0;
    endtask

    task automatic fetch_word(input logic [31:0] w);
        idle_in();
        imem_ready = 1'b1;
        imem_rdata = w;
        cyc();
        imem_ready = 1'b0;
    endtask

    task automatic retire(input logic [1:0] br, input logic z,
                          input logic j, input logic [31:0] imm);
        idle_in();
        instr_ack = 1'b1;
        branch    = br;
        zero      = z;
        jump      = j;
        imm_ext   = imm;
        cyc();
        idle_in();
    endtask

    initial begin
        reset      = 1'b1;
        imem_rdata = 32'h0;
        idle_in();
        cyc();
        cyc();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_p4", pc_plus4, 32'h4);
        reset = 1'b0;
        cyc();
        check("first_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem_addr, 32'(i * 4));
            fetch_word(32'h2408_0000 | 32'(i));
            check("seq_valid", {31'd0, instr_valid}, 32'd1);
            retire(2'b00, 1'b0, 1'b0, 32'h0);
        end
        check("seq_count", retired_count, 32'd4);

        for (int i = 0; i < 3; i++) begin
            cyc();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h10);
        end
        fetch_word(32'h1000_FFFE);
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
        retire(2'b01, 1'b1, 1'b0, 32'hFFFF_FFFE);
        check("beq_taken", imem_addr, 32'h0C);
        fetch_word(32'h2408_0000);
        retire(2'b00, 1'b0, 1'b0, 32'h0);
        fetch_word(32'h1000_FFFE);
        retire(2'b01, 1'b0, 1'b0, 32'hFFFF_FFFE);
        check("beq_not", imem_addr, 32'h14);

        fetch_word(32'h0800_0008);
        retire(2'b00, 1'b0, 1'b1, 32'h0);
        check("j_0x20", imem_addr, 32'h20);
        fetch_word(32'h1400_0003);
        retire(2'b11, 1'b0, 1'b0, 32'h3);
        check("bne_taken", imem_addr, 32'h30);

        fetch_word(32'h1400_FFF3);
        retire(2'b11, 1'b0, 1'b0, 32'h0FFF_FFF3);
        check("far_br", imem_addr, 32'h4000_0000);
        fetch_word(32'h0C00_0100);
        check("jal_p4", pc_plus4, 32'h4000_0004);
        retire(2'bxx, 1'b1, 1'b1, 32'h0);
        check("jal_tgt", imem_addr, 32'h4000_0400);

        fetch_word(32'h1000_0000);
        retire(2'b01, 1'b1, 1'b0, 32'h2FFF_FEFE);
        check("to_top", imem_addr, 32'hFFFF_FFFC);
        fetch_word(32'h2408_0000);
        check("top_p4", pc_plus4, 32'h0);
        retire(2'b00, 1'b0, 1'b0, 32'h0);
        check("pc_wrap", imem_addr, 32'h0);

        fetch_word(32'h2408_0000);
        force dut.count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #2;
        release dut.count_q;
        retire(2'b00, 1'b0, 1'b0, 32'h0);
        check("cnt_wrap", retired_count, 32'h0);

        fetch_word(32'h2408_0000);
        fetch_word(32'h2408_0000);
        retire(2'b00, 1'b0, 1'b0, 32'h0);
        fetch_word(32'h2408_0000);
        reset     = 1'b1;
        instr_ack = 1'b1;
        cyc();
        check("rst_hold_v", {31'd0, instr_valid}, 32'd0);
        check("rst_hold_r", {31'd0, imem_req}, 32'd0);
        check("rst_hold_c", retired_count, 32'd0);
        check("rst_hold_a", imem_addr, RP);
        reset = 1'b0;
        idle_in();
        cyc();
        check("rel_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            imem_ready = ($urandom % 3) != 0;
            imem_rdata = $urandom;
            instr_ack  = ($urandom % 2) == 0;
            branch     = 2'($urandom);
            zero       = 1'($urandom);
            jump       = ($urandom % 4) == 0;
            imm_ext    = $urandom;
            reset      = ($urandom % 97) == 0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
